// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the segment-display scan controller.
//   - scan_state_e : scan FSM states
//   - BCD_W        : width of one BCD digit
//   - DEF_*        : default parameter values for display_scan_ctrl
package display_pkg;

  localparam int BCD_W            = 4;
  localparam int DEF_DIGITS       = 4;
  localparam int DEF_SCAN_DIV     = 1000;
  localparam int DEF_BLANK_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if
//   Load channel between the machine FSM (master) and the scan controller
//   (slave).
//   load_valid  : master offers load_bcd
//   load_ready  : slave can take a value
//   load_bcd    : packed BCD, nibble 0 = least significant digit
//   lz_blank_en : leading-zero blanking enable, level signal
interface display_scan_ctrl_if #(
  parameter int DIGITS = display_pkg::DEF_DIGITS
);
  logic                                load_valid;
  logic                                load_ready;
  logic [display_pkg::BCD_W*DIGITS-1:0] load_bcd;
  logic                                lz_blank_en;

  modport master (output load_valid, load_bcd, lz_blank_en, input load_ready);
  modport slave  (input load_valid, load_bcd, lz_blank_en, output load_ready);
endinterface

// File: rtl/display_scan_tick.sv
// display_scan_tick
//   Slot timer. A down-counter reloaded for a lit slot (SHOW_LEN cycles) or
//   a dark slot (BLANK_LEN cycles); tc is high in the last cycle of the slot.
//   clk, rst_n : clock, async active-low reset
//   ld_show    : reload for a lit slot
//   ld_blank   : reload for a dark slot
//   tc         : terminal count
module display_scan_tick #(
  parameter int SHOW_LEN  = display_pkg::DEF_SCAN_DIV,
  parameter int BLANK_LEN = display_pkg::DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_show,
  input  logic ld_blank,
  output logic tc
);
  localparam int MAXLEN = (SHOW_LEN > BLANK_LEN) ? SHOW_LEN : BLANK_LEN;
  localparam int CW     = $clog2(MAXLEN + 1);
  // Counting down to zero inclusive, so reload with length-1.
  localparam logic [CW-1:0] SHOW_RL  = CW'(SHOW_LEN - 1);
  localparam logic [CW-1:0] BLANK_RL = CW'((BLANK_LEN > 0) ? BLANK_LEN - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (ld_show)        cnt <= SHOW_RL;
    else if (ld_blank)       cnt <= BLANK_RL;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexes a double-buffered DIGITS-digit BCD value onto a single
//   shared segment decoder, with a dark guard interval after each digit.
//   clk, rst_n     : clock, async active-low reset
//   ld             : load channel (slave side)
//   digit_bcd      : nibble for the decoder
//   enable_segment : one-hot digit enable, all-zero = dark
//   frame_done     : one-cycle pulse as the last digit's slot completes
//   Outputs are registered from FSM state, so they trail the state by one
//   cycle; the first digit appears one cycle after the accepting edge.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS       = DEF_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  ld,
  output logic [BCD_W-1:0]    digit_bcd,
  output logic [DIGITS-1:0]   enable_segment,
  output logic                frame_done
);
  localparam int             IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit             HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [IW-1:0]  LAST      = IW'(DIGITS - 1);

  scan_state_e                   state;
  logic [IW-1:0]                 idx, idx_nxt;
  logic [DIGITS-1:0][BCD_W-1:0]  active, pending;
  logic                          pending_full;
  logic                          tc, accept, advance, wrap, ld_show, ld_blank;
  logic [DIGITS-1:0]             lit_ok;

  // pending_full is the only thing that can refuse a value; in IDLE it is
  // always clear, so ready is high there.
  assign ld.load_ready = ~pending_full;
  assign accept        = ld.load_valid & ~pending_full;

  assign advance  = tc & ((state == BLANK) | ((state == SHOW) & ~HAS_BLANK));
  assign wrap     = advance & (idx == LAST);
  assign idx_nxt  = (idx == LAST) ? '0 : idx + 1'b1;
  assign ld_show  = ((state == IDLE) & accept) | advance;
  assign ld_blank = (state == SHOW) & tc & HAS_BLANK;

  // Digit i may light under blanking only if it or some higher digit is
  // non-zero; digit 0 always lights.
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_lsd
      assign lit_ok[i] = 1'b1;
    end else begin : g_hi
      assign lit_ok[i] = |active[DIGITS-1:i];
    end
  end

  display_scan_tick #(
    .SHOW_LEN  (SCAN_DIV),
    .BLANK_LEN (BLANK_CYCLES)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_show  (ld_show),
    .ld_blank (ld_blank),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      active         <= '0;
      pending        <= '0;
      pending_full   <= 1'b0;
      digit_bcd      <= '0;
      enable_segment <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= wrap;

      case (state)
        IDLE: if (accept) begin
          active <= ld.load_bcd;
          idx    <= '0;
          state  <= SHOW;
        end
        SHOW: if (tc) begin
          if (HAS_BLANK) state <= BLANK;
          else           idx   <= idx_nxt;
        end
        BLANK: if (tc) begin
          state <= SHOW;
          idx   <= idx_nxt;
        end
        default: state <= IDLE;
      endcase

      // accept needs !pending_full, so it never collides with the swap.
      if (state != IDLE && accept) begin
        pending      <= ld.load_bcd;
        pending_full <= 1'b1;
      end
      if (wrap && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end

      // BLANK and IDLE keep the last nibble; only the enable goes dark.
      if (state == SHOW) begin
        digit_bcd      <= active[idx];
        enable_segment <= (lit_ok[idx] | ~ld.lz_blank_en) ? (DIGITS'(1) << idx) : '0;
      end else begin
        enable_segment <= '0;
      end
    end
  end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the coffee machine's segment display. It owns a double-buffered multi-digit BCD value and scans the digits one at a time through the single shared `display_if` decoder. It drives the decoder's `bcd` nibble and `enable_segment` one-hot select, and inserts a dark guard interval between digits to prevent ghosting. It sits between the machine FSM, which loads values with a valid/ready handshake, and the `display_if` instance.

## Interface
- `DIGITS`, 4: number of digits scanned; `enable_segment` width.
- `SCAN_DIV`, 1000: clock cycles each digit is lit (≥1).
- `BLANK_CYCLES`, 2: dark cycles after each digit (≥0).

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `load_valid`  in  1  producer offers `load_bcd`.
- `load_ready`  out  1  controller can accept a value.
- `load_bcd`  in  4*DIGITS  packed BCD; nibble 0 = least significant digit.
- `lz_blank_en`  in  1  enable leading-zero blanking; sampled every cycle.
- `digit_bcd`  out  4  nibble to `display_if` `bcd` input.
- `enable_segment`  out  DIGITS  one-hot digit enable, active high; all-zero = dark.
- `frame_done`  out  1  one-cycle pulse when the last digit's slot completes.

## Operation
- States: IDLE, SHOW, BLANK.
- IDLE is the reset state; display dark. The first accepted load writes directly into the active register. The next state is SHOW with digit index 0.
- SHOW: `enable_segment` = one-hot(idx) and `digit_bcd` = active[idx], held for exactly SCAN_DIV cycles. Then:
  - If BLANK_CYCLES > 0: go to BLANK.
  - If BLANK_CYCLES = 0: advance idx directly and stay in SHOW.
- BLANK: `enable_segment` = 0 for BLANK_CYCLES cycles and `digit_bcd` holds its last value. Then idx advances and the state returns to SHOW.
- idx wraps from DIGITS-1 to 0. The wrap cycle is the frame boundary:
  - `frame_done` pulses.
  - If `pending_full`, active ← pending and `pending_full` is cleared.
- Handshake:
  - `load_ready` = !`pending_full`.
  - In IDLE, `load_ready` = 1.
  - Transfer occurs when `load_valid` && `load_ready` at a rising edge.
  - Outside IDLE, an accepted value goes to the pending register and sets `pending_full`.
  - There is no bypass. A value accepted on the boundary cycle is displayed from the following boundary.
- Leading-zero blanking: when `lz_blank_en` = 1, the enable for digit i > 0 is suppressed if active[i] and all higher nibbles are 0. Digit 0 is never suppressed. Slot timing is unchanged; the slot is simply dark.
- Nibbles A–F pass through unchanged; decoding them is the job of `display_if`.
- There is no return to IDLE except by reset.

## Timing
- Reset values:
  - `enable_segment` = 0, `digit_bcd` = 0, `frame_done` = 0, `load_ready` = 1.
  - active = 0, pending = 0, `pending_full` = 0, idx = 0, state = IDLE.
  - Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Load latency from IDLE: accept at edge t; `enable_segment` = 1 and `digit_bcd` = nibble 0 are valid after edge t+1.
- Digit slot length = SCAN_DIV + BLANK_CYCLES cycles. Frame length = DIGITS × slot.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `load_ready` deasserts the cycle after an accept outside IDLE. It reasserts the cycle after the frame boundary.
- `lz_blank_en` changes take effect on the next registered enable update.

## Structure
- Shared package `display_pkg`:
  - state enum typedef (IDLE, SHOW, BLANK);
  - `BCD_W` = 4;
  - default parameter constants.
- One sub-module, `display_scan_tick`: a down-counter reloaded with SCAN_DIV or BLANK_CYCLES that emits a terminal-count strobe. The FSM consumes the strobe.
- `display_if` is instantiated beside this block, not inside it.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1 unless stated otherwise.
- Reset: assert `rst_n` = 0 → all outputs 0 and `load_ready` = 1; display stays dark with no load.
- Load 16'h1234 in IDLE:
  - Next cycle `enable_segment` = 0001, `digit_bcd` = 4 for 4 cycles, then 1 dark cycle.
  - Then 0010/3, 0100/2, 1000/1 in turn.
  - `frame_done` pulses every 20 cycles.
- `lz_blank_en` = 1, load 16'h0050:
  - Slots 0 and 1 lit with 0 and 5; slots 2 and 3 dark with timing preserved.
  - Load 16'h0000: only digit 0 lit.
- Back-pressure:
  - Mid-frame load 16'h5678 is accepted and `load_ready` → 0.
  - 16'h9999 held on `load_valid` is not accepted.
  - After `frame_done`, digits show 8,7,6,5 and `load_ready` = 1; 9999 is then accepted.
- Assert `rst_n` low during a SHOW slot: `enable_segment` goes to 0 without a clock edge, `pending_full` clears, and the controller returns to IDLE.
- BLANK_CYCLES=0: enables step 0001→0010→0100→1000 with no dark cycle; frame length 16 cycles.
